// File: rtl/pc_ctrl_pkg.sv
// Shared types and constants for the PC fetch controller.
package pc_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_VALID = 2'd2,
    ST_FAULT = 2'd3
  } fetch_state_t;

  localparam int unsigned PC_INCR          = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;

endpackage

// File: rtl/fetch_watchdog.sv
// Fetch watchdog: counts consecutive unacknowledged REQ cycles, clears when inactive.
// o_expire is combinational and fires on the cycle that would reach TIMEOUT_CYCLES.
module fetch_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic i_active,
  output logic o_expire
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset || !i_active) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_expire = i_active && (r_cnt == LAST);

endmodule

// File: rtl/pc_fetch_controller.sv
// Instruction fetch sequencer (IDLE/REQ/VALID/FAULT); optional watchdog under FETCH_TIMEOUT_EN.
// One instruction per two cycles with zero-wait memory; stall holds VALID and its outputs.
module pc_fetch_controller
  import pc_ctrl_pkg::*;
#(
  parameter int unsigned N              = 32,
  parameter logic [N-1:0] RESET_PC      = N'(DEFAULT_RESET_PC),
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic         clk,
  input  logic         reset,
  output logic         imem_req,
  output logic [N-1:0] imem_addr,
  input  logic         imem_ack,
  input  logic [N-1:0] imem_rdata,
  input  logic         stall,
  input  logic         redirect_valid,
  input  logic [N-1:0] redirect_pc,
  output logic         instr_valid,
  output logic [N-1:0] instr,
  output logic [N-1:0] instr_pc,
  output logic [N-1:0] pc_value,
  output logic         fetch_fault
);

  localparam logic [N-1:0] ALIGN_MASK = ~N'(3);

  fetch_state_t r_state;
  logic [N-1:0] r_pc;
  logic [N-1:0] r_instr;
  logic [N-1:0] r_instr_pc;
  logic         r_imem_req;
  logic         r_instr_valid;
  logic         w_expire;

`ifdef FETCH_TIMEOUT_EN
  logic r_fault;
  logic w_wd_active;

  assign w_wd_active = (r_state == ST_REQ) && !imem_ack && !redirect_valid;

  fetch_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .i_active(w_wd_active),
    .o_expire(w_expire)
  );

  assign fetch_fault = r_fault;
`else
  assign w_expire    = 1'b0;
  assign fetch_fault = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_pc          <= RESET_PC;
      r_instr       <= '0;
      r_instr_pc    <= '0;
      r_imem_req    <= 1'b0;
      r_instr_valid <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      r_fault       <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_state    <= ST_REQ;
          r_imem_req <= 1'b1;
        end
        ST_REQ: begin
          // Redirect wins over a same-cycle ack; the returned word is dropped.
          if (redirect_valid) begin
            r_pc <= redirect_pc & ALIGN_MASK;
          end else if (imem_ack) begin
            r_instr       <= imem_rdata;
            r_instr_pc    <= r_pc;
            r_pc          <= r_pc + N'(PC_INCR);
            r_state       <= ST_VALID;
            r_imem_req    <= 1'b0;
            r_instr_valid <= 1'b1;
          end else if (w_expire) begin
            r_state    <= ST_FAULT;
            r_imem_req <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            r_fault    <= 1'b1;
`endif
          end
        end
        ST_VALID: begin
          if (redirect_valid) begin
            r_pc          <= redirect_pc & ALIGN_MASK;
            r_state       <= ST_REQ;
            r_imem_req    <= 1'b1;
            r_instr_valid <= 1'b0;
          end else if (!stall) begin
            r_state       <= ST_REQ;
            r_imem_req    <= 1'b1;
            r_instr_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_FAULT;
        end
      endcase
    end
  end

  assign imem_req    = r_imem_req;
  assign imem_addr   = r_pc;
  assign pc_value    = r_pc;
  assign instr_valid = r_instr_valid;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;

endmodule

// File: tb/tb_pc_fetch_controller.sv
// Directed bench for pc_fetch_controller: vector table plus reset-latency and watchdog sequences.
module tb_pc_fetch_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] pc_value;
  logic        fetch_fault;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_fetch_controller #(
    .N(32),
    .RESET_PC(32'h0040_0000),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ack(imem_ack),
    .imem_rdata(imem_rdata),
    .stall(stall),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .instr_valid(instr_valid),
    .instr(instr),
    .instr_pc(instr_pc),
    .pc_value(pc_value),
    .fetch_fault(fetch_fault)
  );

  typedef struct {
    bit        rst;
    bit        ack;
    bit [31:0] rdata;
    bit        stl;
    bit        redir;
    bit [31:0] rpc;
    bit        e_req;
    bit [31:0] e_addr;
    bit        e_vld;
    bit [31:0] e_instr;
    bit [31:0] e_ipc;
  } vec_t;

  vec_t vq[$];

  function automatic void add(bit rst, bit ack, bit [31:0] rdata, bit stl, bit redir,
                              bit [31:0] rpc, bit e_req, bit [31:0] e_addr, bit e_vld,
                              bit [31:0] e_instr, bit [31:0] e_ipc);
    vec_t v;
    v.rst = rst; v.ack = ack; v.rdata = rdata; v.stl = stl; v.redir = redir; v.rpc = rpc;
    v.e_req = e_req; v.e_addr = e_addr; v.e_vld = e_vld; v.e_instr = e_instr; v.e_ipc = e_ipc;
    vq.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic drive(input bit rst, input bit ack, input bit [31:0] rdata, input bit stl,
                       input bit redir, input bit [31:0] rpc);
    reset = rst; imem_ack = ack; imem_rdata = rdata; stall = stl;
    redirect_valid = redir; redirect_pc = rpc;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cnt;
    bit seen;
    drive(1, 0, 0, 0, 0, 0);

    //  rst ack rdata         stl rdr rpc            req addr           vld instr         ipc
    add(1, 0, 32'h0,          0, 0, 32'h0,          0, 32'h0040_0000, 0, 32'h0,          32'h0);
    add(0, 0, 32'h0,          0, 0, 32'h0,          1, 32'h0040_0000, 0, 32'h0,          32'h0);
    add(0, 1, 32'hAAAA_0001,  0, 0, 32'h0,          0, 32'h0040_0004, 1, 32'hAAAA_0001,  32'h0040_0000);
    add(0, 0, 32'h0,          0, 0, 32'h0,          1, 32'h0040_0004, 0, 32'hAAAA_0001,  32'h0040_0000);
    add(0, 0, 32'h0,          0, 0, 32'h0,          1, 32'h0040_0004, 0, 32'hAAAA_0001,  32'h0040_0000);
    add(0, 1, 32'hBBBB_0002,  0, 0, 32'h0,          0, 32'h0040_0008, 1, 32'hBBBB_0002,  32'h0040_0004);
    add(0, 0, 32'h0,          1, 0, 32'h0,          0, 32'h0040_0008, 1, 32'hBBBB_0002,  32'h0040_0004);
    add(0, 1, 32'h1234_5678,  1, 0, 32'h0,          0, 32'h0040_0008, 1, 32'hBBBB_0002,  32'h0040_0004);
    add(0, 0, 32'h0,          1, 0, 32'h0,          0, 32'h0040_0008, 1, 32'hBBBB_0002,  32'h0040_0004);
    add(0, 0, 32'h0,          1, 0, 32'h0,          0, 32'h0040_0008, 1, 32'hBBBB_0002,  32'h0040_0004);
    add(0, 0, 32'h0,          1, 0, 32'h0,          0, 32'h0040_0008, 1, 32'hBBBB_0002,  32'h0040_0004);
    add(0, 0, 32'h0,          0, 0, 32'h0,          1, 32'h0040_0008, 0, 32'hBBBB_0002,  32'h0040_0004);
    add(0, 1, 32'hDEAD_BEEF,  0, 1, 32'h0040_0103,  1, 32'h0040_0100, 0, 32'hBBBB_0002,  32'h0040_0004);
    add(0, 1, 32'hCCCC_0003,  0, 0, 32'h0,          0, 32'h0040_0104, 1, 32'hCCCC_0003,  32'h0040_0100);
    add(0, 0, 32'h0,          1, 1, 32'h0040_0203,  1, 32'h0040_0200, 0, 32'hCCCC_0003,  32'h0040_0100);
    add(0, 0, 32'h0,          0, 1, 32'hFFFF_FFFF,  1, 32'hFFFF_FFFC, 0, 32'hCCCC_0003,  32'h0040_0100);
    add(0, 1, 32'h1111_2222,  0, 0, 32'h0,          0, 32'h0000_0000, 1, 32'h1111_2222,  32'hFFFF_FFFC);
    add(0, 0, 32'h0,          0, 0, 32'h0,          1, 32'h0000_0000, 0, 32'h1111_2222,  32'hFFFF_FFFC);
    add(1, 1, 32'h9999_9999,  0, 0, 32'h0,          0, 32'h0040_0000, 0, 32'h0,          32'h0);
    add(0, 0, 32'h0,          0, 0, 32'h0,          1, 32'h0040_0000, 0, 32'h0,          32'h0);
    add(1, 0, 32'h0,          0, 0, 32'h0,          0, 32'h0040_0000, 0, 32'h0,          32'h0);
    add(0, 0, 32'h0,          0, 1, 32'h0050_0000,  1, 32'h0040_0000, 0, 32'h0,          32'h0);

    #2;
    foreach (vq[i]) begin
      drive(vq[i].rst, vq[i].ack, vq[i].rdata, vq[i].stl, vq[i].redir, vq[i].rpc);
      step();
      check($sformatf("v%0d.imem_req", i), 32'(imem_req), 32'(vq[i].e_req));
      check($sformatf("v%0d.imem_addr", i), imem_addr, vq[i].e_addr);
      check($sformatf("v%0d.pc_value", i), pc_value, vq[i].e_addr);
      check($sformatf("v%0d.instr_valid", i), 32'(instr_valid), 32'(vq[i].e_vld));
      check($sformatf("v%0d.instr", i), instr, vq[i].e_instr);
      check($sformatf("v%0d.instr_pc", i), instr_pc, vq[i].e_ipc);
      check($sformatf("v%0d.fetch_fault", i), 32'(fetch_fault), 32'd0);
    end

    // Reset-to-first-valid latency with a memory that always acks.
    drive(1, 0, 0, 0, 0, 0);
    step();
    drive(0, 1, 32'h5555_AAAA, 0, 0, 0);
    cnt = 0;
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      step();
      cnt++;
      if (instr_valid) seen = 1;
    end
    check("lat.seen", 32'(seen), 32'd1);
    check("lat.edges", 32'(cnt), 32'd2);
    check("lat.instr_pc", instr_pc, 32'h0040_0000);
    drive(0, 0, 0, 0, 0, 0);
    step();
    check("lat.next_addr", imem_addr, 32'h0040_0004);
    check("lat.next_req", 32'(imem_req), 32'd1);

`ifdef FETCH_TIMEOUT_EN
    drive(1, 0, 0, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0);
    step();
    for (int k = 0; k < 3; k++) step();
    check("wd.before", 32'(fetch_fault), 32'd0);
    check("wd.req_before", 32'(imem_req), 32'd1);
    step();
    check("wd.fault", 32'(fetch_fault), 32'd1);
    check("wd.req_off", 32'(imem_req), 32'd0);
    drive(0, 1, 32'h1, 0, 1, 32'h0070_0000);
    step();
    check("wd.redir_ignored", 32'(fetch_fault), 32'd1);
    check("wd.redir_pc", pc_value, 32'h0040_0000);
    check("wd.redir_req", 32'(imem_req), 32'd0);
    drive(1, 0, 0, 0, 0, 0);
    step();
    check("wd.reset_clears", 32'(fetch_fault), 32'd0);
    drive(0, 0, 0, 0, 0, 0);
`else
    // Without the watchdog, REQ waits indefinitely.
    drive(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 300; k++) step();
    check("nowd.req_held", 32'(imem_req), 32'd1);
    check("nowd.no_fault", 32'(fetch_fault), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
